// File: rtl/sequential_multiplier_hs.sv
// Iterative radix-2 shift-add multiplier, one partial product per clock,
// with start/busy/done handshake and optional two's-complement operands.
module sequential_multiplier_hs #(
  parameter int N = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [N-1:0]     inputA,
  input  logic [N-1:0]     inputB,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   result
);

  // state | meaning
  // IDLE  | waiting for start; busy=0, done=0
  // RUN   | one shift-add iteration per edge; busy=1
  // DONE  | result just updated; done=1 for one cycle, start accepted here too
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = $clog2(N) + 1;

  state_t          state;
  logic [CW-1:0]   count;
  logic [2*N-1:0]  mcand;
  logic [2*N-1:0]  acc;
  logic [N-1:0]    mplier;
  logic            negate;

  logic [N-1:0]    abs_a;
  logic [N-1:0]    abs_b;
  logic [2*N-1:0]  acc_next;
  logic            take;

  always_comb begin
    abs_a    = (signed_mode && inputA[N-1]) ? -inputA : inputA;
    abs_b    = (signed_mode && inputB[N-1]) ? -inputB : inputB;
    acc_next = mplier[0] ? (acc + mcand) : acc;
    take     = start && ((state == IDLE) || (state == DONE));
  end

  // The multiplicand register shifts left each iteration, which is the same
  // as adding (multiplicand << count) against a fixed register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      negate <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else if (take) begin
      mcand  <= {{N{1'b0}}, abs_a};
      mplier <= abs_b;
      acc    <= '0;
      negate <= signed_mode & (inputA[N-1] ^ inputB[N-1]);
      count  <= '0;
      state  <= RUN;
      busy   <= 1'b1;
      done   <= 1'b0;
    end else if (state == RUN) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
      if (count == CW'(N - 1)) begin
        // Final iteration's sum is folded into the result on this same edge.
        result <= negate ? -acc_next : acc_next;
        state  <= DONE;
        busy   <= 1'b0;
        done   <= 1'b1;
      end
    end else if (state == DONE) begin
      state <= IDLE;
      done  <= 1'b0;
    end
  end

endmodule
